alif_cfg_serializer: RTL
========================

Name: alif_cfg_serializer

Overview:
- Host-side initiator for the neuron's serial configuration interface.
- Accepts a parallel parameter image via a valid/ready handshake and streams it MSB-first on serial_data, framed by load_mode.
- Then waits for the neuron's params_ready confirmation, with a timeout.
- Sits between an on-chip controller or test harness and the ALIF neuron core; it drives that core's load_mode and serial_data and observes its params_ready.

Parameters:
- NUM_PARAMS, 5, number of parameter fields in one configuration frame
- PARAM_W, 8, bits per parameter field; frame length FRAME_BITS = NUM_PARAMS*PARAM_W
- BIT_DIV, 1, clk cycles each serial bit is held (must be >= 1)
- READY_TIMEOUT, 255, max cycles spent in WAIT_RDY before an error is flagged (must be >= 1)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- cfg_data  input  FRAME_BITS  parameter image; field 0 in the MSBs, sent first
- cfg_valid  input  1  cfg_data is valid
- cfg_ready  output  1  block can accept a frame (high only in IDLE)
- abort  input  1  synchronous cancel of any frame in flight
- load_mode  output  1  configuration frame strobe to the neuron
- serial_data  output  1  serial configuration bit to the neuron
- params_ready  input  1  neuron's "parameters loaded" status (same clock domain, no synchroniser)
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse: frame confirmed
- error  output  1  one-cycle pulse: confirmation timeout

Behaviour:
- Reset (rst_n low, async): state=IDLE; load_mode=0, serial_data=0, busy=0, done=0, error=0, cfg_ready=1 once rst_n is released; shift register, counters and seen_low are cleared.
- All outputs except cfg_ready are registered. cfg_ready is combinational: (state==IDLE) & ~abort.
- States:
  - IDLE: on cfg_valid & cfg_ready, latch cfg_data into the shift register, then go to LOAD.
  - LOAD: shift out FRAME_BITS bits, then go to WAIT_RDY.
  - WAIT_RDY: wait for confirmation; go to IDLE with done or error.
- Latency: handshake at edge k -> load_mode=1 and serial_data=cfg_data[MSB] visible after edge k.
  - Each bit is held exactly BIT_DIV cycles.
  - load_mode is high for exactly FRAME_BITS*BIT_DIV consecutive cycles, with no gaps.
- End of frame: on the edge after the last bit's final cycle, load_mode=0, serial_data=0, state=WAIT_RDY, and the timeout counter is cleared.
- Stale-ready guard: the seen_low flag is cleared on acceptance and set on any cycle in LOAD or WAIT_RDY where params_ready==0.
  - Confirmation requires seen_low & params_ready, sampled in WAIT_RDY.
  - A params_ready level held high across the whole frame never confirms the frame.
- Confirmation: done pulses high for 1 cycle; the state returns to IDLE on the same edge. cfg_ready is high on the following cycle. Back-to-back frames are allowed, with a minimum 1 idle cycle.
- Timeout: the counter increments each WAIT_RDY cycle without confirmation.
  - When it reaches READY_TIMEOUT, error pulses for 1 cycle and the state goes to IDLE.
  - If confirmation and the timeout occur on the same cycle, confirmation wins (done, no error).
- Abort (any non-IDLE state): next edge -> IDLE, load_mode=0, serial_data=0, no done/error pulse.
  - In IDLE, abort blocks acceptance for that cycle; abort takes priority over cfg_valid.
- cfg_data changes after acceptance have no effect on the frame in flight.
- Width rules:
  - Bit counter: clog2(FRAME_BITS+1) bits.
  - Divider counter: clog2(BIT_DIV+1) bits.
  - Timeout counter: clog2(READY_TIMEOUT+1) bits.
  - No counter wraps: each saturates or clears at its terminal value.
- Async reset mid-frame: load_mode drops immediately (asynchronously); no pulse is generated.

Decomposition:
- Shared package alif_cfg_pkg holds:
  - the state enum (IDLE, LOAD, WAIT_RDY);
  - default NUM_PARAMS and PARAM_W, shared with the neuron's receiver so frame lengths match;
  - field index constants for the parameter fields.
- One natural sub-module, alif_cfg_bit_timer: the BIT_DIV divider that emits a bit_tick strobe, so the FSM advances only on bit_tick. Everything else lives in the top FSM.

Test Plan:
- Basic frame (BIT_DIV=1): cfg_data=40'hA5_3C_0F_81_7E; params_ready low during LOAD, rises 3 cycles after load_mode falls.
  - Expected: 40 cycles of load_mode=1 carrying the bits 1010_0101... MSB-first, then done pulse 3 cycles later, busy=0 next cycle.
- Divided bit rate (BIT_DIV=4), same frame.
  - Expected: each bit stable 4 cycles, load_mode high 160 cycles, done on confirmation.
- Timeout: params_ready stuck 0.
  - Expected: error pulse exactly READY_TIMEOUT=255 cycles after entering WAIT_RDY; no done; cfg_ready=1 afterwards.
- Stale ready: params_ready held 1 throughout.
  - Expected: no done; error after 255 cycles.
  - Repeat with params_ready pulsed 0 for 1 cycle mid-LOAD: done on the first WAIT_RDY cycle.
- Abort at bit 17.
  - Expected: load_mode=0 and serial_data=0 next cycle, no done/error, cfg_ready=1; a new frame 0x0000000001 completes correctly.
  - Also: abort and cfg_valid together in IDLE -> no acceptance.
- Reset mid-LOAD (rst_n low at bit 10).
  - Expected: load_mode=0 asynchronously; after release all outputs are at reset values and the next frame is sent intact.

Source files
------------

// File: rtl/alif_cfg_pkg.sv
// ---------------------------------------------------------------------------
// alif_cfg_pkg
// Definitions shared by the ALIF configuration serializer and the neuron's
// serial receiver, so that both sides agree on the frame layout.
//   - cfg_state_e    : serializer FSM states
//   - NUM_PARAMS_DEF : default number of parameter fields per frame
//   - PARAM_W_DEF    : default bits per parameter field
//   - FIELD_*        : field indices; field 0 occupies the frame MSBs
//   - field_lsb()    : bit position of a field's LSB inside the frame
// ---------------------------------------------------------------------------
package alif_cfg_pkg;

    localparam int NUM_PARAMS_DEF = 5;
    localparam int PARAM_W_DEF    = 8;

    // Field order on the wire. Field 0 is transmitted first.
    localparam int FIELD_V_TH   = 0;  // firing threshold
    localparam int FIELD_TAU_M  = 1;  // membrane leak constant
    localparam int FIELD_TAU_A  = 2;  // adaptation decay constant
    localparam int FIELD_A_INC  = 3;  // adaptation increment per spike
    localparam int FIELD_REFRAC = 4;  // refractory period

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_RDY = 2'd2
    } cfg_state_e;

    function automatic int field_lsb(input int idx, input int num_params,
                                     input int param_w);
        return (num_params - 1 - idx) * param_w;
    endfunction

endpackage

// File: rtl/alif_cfg_bit_timer.sv
// ---------------------------------------------------------------------------
// alif_cfg_bit_timer
// Serial bit-rate divider. While run is high it emits one bit_tick every
// BIT_DIV cycles; the serializer advances to the next bit only on bit_tick.
// When run is low the count is held at zero, so the first bit of a frame is
// always held for a full BIT_DIV cycles, even after an aborted frame.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   run      in  divider enabled (serializer is shifting)
//   bit_tick out last cycle of the current bit period (combinational)
// ---------------------------------------------------------------------------
module alif_cfg_bit_timer #(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(BIT_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_tick = run & (cnt == CNT_LAST);

    // NOTE: sequential state is always written with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alif_cfg_serializer.sv
// ---------------------------------------------------------------------------
// alif_cfg_serializer
// Host-side initiator for the ALIF neuron's serial configuration port.
// Accepts a parameter image over valid/ready, streams it MSB-first on
// serial_data while load_mode frames it, then waits for the neuron's
// params_ready confirmation with a timeout.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   cfg_data     in   parameter image, field 0 in the MSBs (sent first)
//   cfg_valid    in   cfg_data is valid
//   cfg_ready    out  frame can be accepted (IDLE and no abort)
//   abort        in   synchronous cancel of any frame in flight
//   load_mode    out  configuration frame strobe to the neuron
//   serial_data  out  serial configuration bit to the neuron
//   params_ready in   neuron's "parameters loaded" status
//   busy         out  a frame is in flight
//   done         out  one-cycle pulse: frame confirmed
//   error        out  one-cycle pulse: confirmation timeout
// ---------------------------------------------------------------------------
module alif_cfg_serializer
    import alif_cfg_pkg::*;
#(
    parameter int NUM_PARAMS    = NUM_PARAMS_DEF,
    parameter int PARAM_W       = PARAM_W_DEF,
    parameter int BIT_DIV       = 1,
    parameter int READY_TIMEOUT = 255,
    localparam int FRAME_BITS   = NUM_PARAMS * PARAM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  abort,
    output logic                  load_mode,
    output logic                  serial_data,
    input  logic                  params_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int BIT_CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TMO_W     = $clog2(READY_TIMEOUT + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(READY_TIMEOUT - 1);

    cfg_state_e            state;
    logic [FRAME_BITS-1:0] shreg;     // bits still to send, next one in MSB
    logic [BIT_CNT_W-1:0]  bit_cnt;   // index of the bit currently on the wire
    logic [TMO_W-1:0]      tmo_cnt;   // WAIT_RDY cycles spent without confirmation
    logic                  seen_low;  // params_ready was low at least once this frame
    logic                  bit_tick;

    // The only combinational output: abort must block acceptance in the
    // same cycle it is raised.
    assign cfg_ready = (state == IDLE) & ~abort;

    alif_cfg_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state == LOAD),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift register and counters are reset along with the
            // control state so no stale frame data survives a reset.
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            seen_low    <= 1'b0;
            load_mode   <= 1'b0;
            serial_data <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;

            // Stale-ready guard: a level that was already high before the
            // frame started must be seen to drop before it can confirm.
            if (state != IDLE && !params_ready) begin
                seen_low <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        serial_data <= cfg_data[FRAME_BITS-1];
                        shreg       <= cfg_data << 1;
                        bit_cnt     <= '0;
                        seen_low    <= 1'b0;
                        load_mode   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end

                LOAD: begin
                    if (abort) begin
                        load_mode   <= 1'b0;
                        serial_data <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (bit_tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            load_mode   <= 1'b0;
                            serial_data <= 1'b0;
                            bit_cnt     <= '0;
                            tmo_cnt     <= '0;
                            state       <= WAIT_RDY;
                        end else begin
                            serial_data <= shreg[FRAME_BITS-1];
                            shreg       <= shreg << 1;
                            bit_cnt     <= bit_cnt + 1'b1;
                        end
                    end
                end

                WAIT_RDY: begin
                    // Priority: abort, then confirmation, then timeout.
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (seen_low && params_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: begin
                    load_mode   <= 1'b0;
                    serial_data <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
